// File: rtl/lsu_pkg.sv
// Shared state encoding, funct3/size codes and the size-to-byte-mask helper
// for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    // Store size codes double as the internal access size (load funct3[1:0] matches).
    localparam logic [1:0] SB = 2'b00;
    localparam logic [1:0] SH = 2'b01;
    localparam logic [1:0] SW = 2'b10;

    function automatic logic [3:0] size_to_mask(input logic [1:0] size);
        logic [3:0] m;
        case (size)
            SB:      m = 4'b0001;
            SH:      m = 4'b0011;
            SW:      m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store enables/data spread over two words, and load
// extraction plus sign/zero extension from the two-word read buffer.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic [31:0] st_data,
    input  logic [63:0] rbuf,
    input  logic        uns,
    output logic [7:0]  be8,
    output logic [63:0] wide,
    output logic [31:0] res
);
    logic [4:0]  sh_amt;
    logic [31:0] sh;

    assign sh_amt = {off, 3'b000};
    assign be8    = {4'b0000, size_to_mask(size)} << off;
    assign wide   = {32'h0, st_data} << sh_amt;
    assign sh     = 32'(rbuf >> sh_amt);

    always_comb begin
        res = sh;
        case (size)
            SB:      res = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            SH:      res = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: res = sh;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: turns one decoded memory op into one or two word
// beats on a req/ack bus, stalling the core until the access completes.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_vld,
    input  logic        mem_wren,
    input  logic [31:0] addr,
    input  logic [31:0] st_data,
    input  logic [2:0]  l_length,
    input  logic        l_unsigned,
    input  logic [1:0]  s_length,
    output logic        stall,
    output logic [31:0] ld_data,
    output logic        done,
    output logic        err,
    output logic        m_req,
    output logic        m_we,
    output logic [29:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_be,
    input  logic        m_ack,
    input  logic [31:0] m_rdata
);
    state_t      state;
    logic        we_q, uns_q;
    logic [1:0]  off_q, size_q;
    logic [31:0] data_q;
    logic [29:0] waddr_q;
    logic [63:0] rbuf, rbuf_nx;
    logic [1:0]  size_in, off_sel, size_sel;
    logic [31:0] data_sel, res;
    logic        illegal, misal;
    logic [7:0]  be8;
    logic [63:0] wide;

    always_comb begin
        size_in = mem_wren ? s_length : l_length[1:0];
        illegal = mem_wren ? (s_length == 2'b11)
                           : !(l_length inside {LB, LH, LW, LBU, LHU});
        misal   = (size_in == SH && addr[0]) || (size_in == SW && addr[1:0] != 2'b00);
    end

    // In IDLE the lanes come straight from the request so beat 0 can be
    // registered on the accepting edge; afterwards from the latched copy.
    assign off_sel  = (state == IDLE) ? addr[1:0] : off_q;
    assign size_sel = (state == IDLE) ? size_in   : size_q;
    assign data_sel = (state == IDLE) ? st_data   : data_q;

    // Merge the beat arriving now so the final ack can register ld_data directly.
    always_comb begin
        rbuf_nx = rbuf;
        if (state == ACC0) rbuf_nx[31:0]  = m_rdata;
        if (state == ACC1) rbuf_nx[63:32] = m_rdata;
    end

    lsu_align u_align (
        .off     (off_sel),
        .size    (size_sel),
        .st_data (data_sel),
        .rbuf    (rbuf_nx),
        .uns     (uns_q),
        .be8     (be8),
        .wide    (wide),
        .res     (res)
    );

    assign stall = (state == IDLE && req_vld) || state == ACC0 || state == ACC1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            off_q   <= 2'b00;
            size_q  <= 2'b00;
            data_q  <= 32'h0;
            waddr_q <= 30'h0;
            rbuf    <= 64'h0;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= 30'h0;
            m_wdata <= 32'h0;
            m_be    <= 4'h0;
            ld_data <= 32'h0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: if (req_vld) begin
                    we_q    <= mem_wren;
                    uns_q   <= l_unsigned;
                    off_q   <= addr[1:0];
                    size_q  <= size_in;
                    data_q  <= st_data;
                    waddr_q <= addr[31:2];
                    if (illegal || (!MISALIGN_EN && misal)) begin
                        state <= DONE;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else begin
                        state   <= ACC0;
                        m_req   <= 1'b1;
                        m_we    <= mem_wren;
                        m_addr  <= addr[31:2];
                        m_be    <= be8[3:0];
                        m_wdata <= wide[31:0];
                    end
                end
                ACC0: if (m_ack) begin
                    rbuf <= rbuf_nx;
                    if (be8[7:4] != 4'h0) begin
                        state   <= ACC1;
                        m_addr  <= waddr_q + 30'd1;
                        m_be    <= be8[7:4];
                        m_wdata <= wide[63:32];
                    end else begin
                        state <= DONE;
                        m_req <= 1'b0;
                        done  <= 1'b1;
                        if (!we_q) ld_data <= res;
                    end
                end
                ACC1: if (m_ack) begin
                    rbuf  <= rbuf_nx;
                    state <= DONE;
                    m_req <= 1'b0;
                    done  <= 1'b1;
                    if (!we_q) ld_data <= res;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: byte-level reference memory, randomized
// memory latency, and a separate MISALIGN_EN=0 instance.
module tb_lsu_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_vld = 0, mem_wren = 0, l_unsigned = 0, m_ack = 0;
    logic [31:0] addr = 0, st_data = 0, m_rdata = 0;
    logic [2:0]  l_length = 0;
    logic [1:0]  s_length = 0;
    logic        stall, done, err, m_req, m_we;
    logic [31:0] ld_data, m_wdata;
    logic [29:0] m_addr;
    logic [3:0]  m_be;

    logic        req2 = 0;
    logic [31:0] addr2 = 0;
    logic [2:0]  ll2 = 0;
    logic        stall2, done2, err2, m_req2, m_we2;
    logic [31:0] ld2, m_wdata2;
    logic [29:0] m_addr2;
    logic [3:0]  m_be2;

    lsu_ctrl #(.MISALIGN_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .mem_wren(mem_wren), .addr(addr),
        .st_data(st_data), .l_length(l_length), .l_unsigned(l_unsigned), .s_length(s_length),
        .stall(stall), .ld_data(ld_data), .done(done), .err(err), .m_req(m_req), .m_we(m_we),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be), .m_ack(m_ack), .m_rdata(m_rdata)
    );

    lsu_ctrl #(.MISALIGN_EN(1'b0)) dut2 (
        .clk(clk), .rst(rst), .req_vld(req2), .mem_wren(1'b0), .addr(addr2),
        .st_data(32'h0), .l_length(ll2), .l_unsigned(1'b0), .s_length(2'b00),
        .stall(stall2), .ld_data(ld2), .done(done2), .err(err2), .m_req(m_req2), .m_we(m_we2),
        .m_addr(m_addr2), .m_wdata(m_wdata2), .m_be(m_be2), .m_ack(m_req2), .m_rdata(32'h8001FF7F)
    );

    typedef struct { logic [29:0] waddr; logic [3:0] be; logic we; logic [31:0] wdata; } beat_t;
    typedef struct { logic err; logic chk_ld; logic [31:0] ld; } exp_t;

    beat_t beatq[$];
    exp_t  expq[$];
    exp_t  mon_e;
    logic [7:0] rmem [logic [31:0]];
    logic [7:0] dmem [logic [31:0]];
    int checks = 0, errors = 0;
    int dly_lo = 0, dly_hi = 0, cur_delay = 0, wcnt = 0, hold_after = -1;
    int acks_acc = 0, waits_acc = 0, stall_cnt = 0;
    logic [31:0] last_ld = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return (a[7:0] * 8'd37) ^ a[15:8] ^ 8'hA5;
    endfunction
    function automatic logic [7:0] rget(input logic [31:0] a);
        return rmem.exists(a) ? rmem[a] : init_byte(a);
    endfunction
    function automatic logic [7:0] dget(input logic [31:0] a);
        return dmem.exists(a) ? dmem[a] : init_byte(a);
    endfunction

    task automatic poke_word(input logic [31:0] a, input logic [31:0] w);
        for (int j = 0; j < 4; j++) begin
            rmem[a + 32'(j)] = w[8*j +: 8];
            dmem[a + 32'(j)] = w[8*j +: 8];
        end
    endtask

    // Reference: walk the accessed bytes one at a time in byte-address space.
    task automatic push_op(input logic st, input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] ll, input logic lu, input logic [1:0] sl);
        int n, k;
        exp_t e;
        beat_t b [2];
        logic [31:0] ba, val;
        n = 0;
        if (st) case (sl)
            2'b00: n = 1; 2'b01: n = 2; 2'b10: n = 4; default: n = 0;
        endcase else case (ll)
            3'b000, 3'b100: n = 1; 3'b001, 3'b101: n = 2; 3'b010: n = 4; default: n = 0;
        endcase
        e.err = (n == 0);
        e.chk_ld = (n != 0);
        if (n != 0) begin
            for (int q = 0; q < 2; q++) begin
                b[q].waddr = a[31:2] + 30'(q);
                b[q].be = 4'h0; b[q].we = st; b[q].wdata = 32'h0;
            end
            val = 32'h0;
            for (int i = 0; i < n; i++) begin
                ba = a + 32'(i);
                k = (ba[31:2] == a[31:2]) ? 0 : 1;
                b[k].be[ba[1:0]] = 1'b1;
                b[k].wdata[8*ba[1:0] +: 8] = d[8*i +: 8];
                if (st) rmem[ba] = d[8*i +: 8];
                else val[8*i +: 8] = rget(ba);
            end
            if (!st) begin
                if (!lu && n < 4 && val[8*n-1]) val = val | (32'hFFFFFFFF << (8*n));
                last_ld = val;
            end
            beatq.push_back(b[0]);
            if (b[1].be != 4'h0) beatq.push_back(b[1]);
        end
        e.ld = last_ld;
        expq.push_back(e);
    endtask

    task automatic drive(input logic st, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] ll, input logic lu, input logic [1:0] sl);
        req_vld = 1'b1; mem_wren = st; addr = a; st_data = d;
        l_length = ll; l_unsigned = lu; s_length = sl;
    endtask

    // Called at posedge+1; request held through DONE as a stalled core would.
    task automatic run(input logic st, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] ll, input logic lu, input logic [1:0] sl);
        int c;
        push_op(st, a, d, ll, lu, sl);
        drive(st, a, d, ll, lu, sl);
        c = 0;
        do begin @(negedge clk); c++; end while (!done && c < 40);
        if (!done) begin
            checks++; errors++;
            $display("FAIL timeout: no done for addr %h", a);
            expq.delete(); beatq.delete();
        end
        @(posedge clk); #1;
        req_vld = 1'b0;
    endtask

    task automatic run2(input logic [31:0] a, input logic [2:0] ll, input logic exp_err,
                        input logic [31:0] exp_ld);
        int c;
        logic saw_req;
        req2 = 1'b1; addr2 = a; ll2 = ll; saw_req = 1'b0; c = 0;
        do begin @(negedge clk); c++; if (m_req2) saw_req = 1'b1; end while (!done2 && c < 10);
        chk("mis_done", 32'(done2), 32'd1);
        chk("mis_err", 32'(err2), 32'(exp_err));
        chk("mis_req", 32'(saw_req), 32'(!exp_err));
        chk("mis_latency", c, exp_err ? 32'd2 : 32'd3);
        if (!exp_err) chk("mis_ld", ld2, exp_ld);
        @(posedge clk); #1;
        req2 = 1'b0;
    endtask

    // Memory responder: checks each presented beat and acks after a random wait.
    always @(negedge clk) begin
        if (rst) begin
            m_ack = 1'b0; wcnt = 0;
        end else if (m_req) begin
            if (beatq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_beat: got addr %h expected none", m_addr);
                m_ack = 1'b0;
            end else begin
                chk("beat_addr", 32'(m_addr), 32'(beatq[0].waddr));
                chk("beat_be", 32'(m_be), 32'(beatq[0].be));
                chk("beat_we", 32'(m_we), 32'(beatq[0].we));
                if (hold_after >= 0 && acks_acc >= hold_after) begin
                    m_ack = 1'b0;
                end else if (wcnt < cur_delay) begin
                    m_ack = 1'b0; wcnt++; waits_acc++; m_rdata = $urandom;
                end else begin
                    m_ack = 1'b1;
                    for (int j = 0; j < 4; j++) m_rdata[8*j +: 8] = dget({m_addr, 2'b00} + 32'(j));
                    if (m_we) begin
                        logic [31:0] msk;
                        for (int j = 0; j < 4; j++) msk[8*j +: 8] = {8{m_be[j]}};
                        chk("beat_wdata", m_wdata & msk, beatq[0].wdata);
                        for (int j = 0; j < 4; j++)
                            if (m_be[j]) dmem[{m_addr, 2'b00} + 32'(j)] = m_wdata[8*j +: 8];
                    end
                    void'(beatq.pop_front());
                    acks_acc++; wcnt = 0;
                    cur_delay = $urandom_range(dly_hi, dly_lo);
                end
            end
        end else begin
            m_ack = ($urandom_range(0, 3) == 0);
            m_rdata = $urandom;
        end
    end

    // Completion monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        if (rst) begin
            stall_cnt = 0; acks_acc = 0; waits_acc = 0;
        end else begin
            if (stall) stall_cnt++;
            if (done) begin
                if (expq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got done=1 expected 0");
                end else begin
                    mon_e = expq.pop_front();
                    chk("err", 32'(err), 32'(mon_e.err));
                    if (mon_e.chk_ld) chk("ld_data", ld_data, mon_e.ld);
                    chk("stall_cycles", stall_cnt, mon_e.err ? 32'd1 : 32'(1 + acks_acc + waits_acc));
                    chk("beats_left", beatq.size(), 32'd0);
                end
                stall_cnt = 0; acks_acc = 0; waits_acc = 0;
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  ll;
        logic [1:0]  sl;
        int r;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_m_req", 32'(m_req), 32'd0);
        chk("rst_m_we", 32'(m_we), 32'd0);
        chk("rst_m_addr", 32'(m_addr), 32'd0);
        chk("rst_m_be", 32'(m_be), 32'd0);
        chk("rst_m_wdata", m_wdata, 32'd0);
        chk("rst_ld_data", ld_data, 32'd0);
        chk("rst_done_err", {30'd0, done, err}, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;

        run2(32'h1, 3'b001, 1'b1, 32'h0);
        run2(32'h2, 3'b001, 1'b0, 32'hFFFF8001);
        run2(32'h2, 3'b010, 1'b1, 32'h0);
        run2(32'h3, 3'b000, 1'b0, 32'hFFFFFF80);

        run(1'b1, 32'h100, 32'hDEADBEEF, 3'b000, 1'b0, 2'b10);
        poke_word(32'h200, 32'h80112233);
        run(1'b0, 32'h203, 32'h0, 3'b000, 1'b0, 2'b00);
        run(1'b0, 32'h203, 32'h0, 3'b100, 1'b1, 2'b00);
        poke_word(32'h100, 32'h11223344);
        poke_word(32'h104, 32'h55667788);
        run(1'b0, 32'h102, 32'h0, 3'b010, 1'b0, 2'b00);
        run(1'b1, 32'h3FF, 32'h1234ABCD, 3'b000, 1'b0, 2'b01);
        run(1'b1, 32'hFFFFFFFF, 32'h0000ABCD, 3'b000, 1'b0, 2'b01);
        run(1'b0, 32'hFFFFFFFF, 32'h0, 3'b001, 1'b0, 2'b00);
        run(1'b0, 32'h100, 32'h0, 3'b011, 1'b0, 2'b00);
        run(1'b0, 32'h102, 32'h0, 3'b010, 1'b0, 2'b00);

        // Slow beat 0, then a beat 1 that never acks; reset abandons it.
        dly_lo = 3; dly_hi = 3; cur_delay = 3; hold_after = 1;
        push_op(1'b0, 32'h102, 32'h0, 3'b010, 1'b0, 2'b00);
        drive(1'b0, 32'h102, 32'h0, 3'b010, 1'b0, 2'b00);
        repeat (7) @(negedge clk);
        chk("hold_m_req", 32'(m_req), 32'd1);
        chk("hold_m_addr", 32'(m_addr), 32'h41);
        chk("hold_m_be", 32'(m_be), 32'h3);
        chk("hold_stall", 32'(stall), 32'd1);
        chk("hold_ld_data", ld_data, 32'h77881122);
        @(posedge clk); #1;
        rst = 1'b1; req_vld = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_m_req", 32'(m_req), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_ld_data", ld_data, 32'd0);
        chk("midrst_stall", 32'(stall), 32'd0);
        expq.delete(); beatq.delete();
        last_ld = 32'h0; hold_after = -1; cur_delay = 0;
        @(posedge clk); #1;

        dly_lo = 0; dly_hi = 2;
        for (int t = 0; t < 300; t++) begin
            r = $urandom_range(0, 2);
            if (r == 0)      a = 32'h100 + 32'($urandom_range(0, 31));
            else if (r == 1) a = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
            else             a = 32'($urandom_range(0, 15));
            ll = 3'($urandom_range(0, 7));
            if ((ll == 3'b011 || ll[2:1] == 2'b11) && $urandom_range(0, 3) != 0) ll = 3'b010;
            sl = 2'($urandom_range(0, 3));
            if (sl == 2'b11 && $urandom_range(0, 3) != 0) sl = 2'b00;
            run(1'($urandom_range(0, 1)), a, $urandom, ll, 1'($urandom_range(0, 1)), sl);
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end

        repeat (3) @(posedge clk);
        chk("final_expq_empty", expq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
